// File: rtl/led_seq_ctrl.sv
// LED sequencer: drives NumLed active-low LEDs in forward chase, reverse chase,
// all-blink or off mode. Phase lengths are counted in prescaler ticks; each LED
// has its own on-time and every on-phase is followed by a fixed all-off gap.
// Mode and on-times are captured in shadow registers only at frame boundaries.
//
// Ports
//   clk_i          system clock
//   rst_ni         synchronous reset, active low
//   en_i           1 = run, 0 = hold every piece of state
//   mode_i         00 fwd chase, 01 rev chase, 10 all-blink, 11 off
//   dur_i          per-LED on-time in ticks, LED i = dur_i[i*DurW +: DurW]
//   led_n_o        LED drive, 0 = lit
//   cur_idx_o      lit LED index + 1 while on in a chase mode, else 0
//   frame_done_o   single-cycle pulse on the edge that ends a frame
module led_seq_ctrl #(
    parameter int unsigned ClkDiv   = 50_000_000,
    parameter int unsigned NumLed   = 4,
    parameter int unsigned DurW     = 4,
    parameter int unsigned GapTicks = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     en_i,
    input  logic [1:0]               mode_i,
    input  logic [NumLed*DurW-1:0]   dur_i,
    output logic [NumLed-1:0]        led_n_o,
    output logic [$clog2(NumLed):0]  cur_idx_o,
    output logic                     frame_done_o
);

    localparam int unsigned PreW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
    localparam int unsigned IdxW = (NumLed > 1) ? $clog2(NumLed) : 1;
    localparam int unsigned CurW = $clog2(NumLed) + 1;

    localparam logic [1:0] ModeFwd = 2'd0;
    localparam logic [1:0] ModeRev = 2'd1;
    localparam logic [1:0] ModeAll = 2'd2;
    localparam logic [1:0] ModeOff = 2'd3;

    localparam logic [PreW-1:0] PreLast = PreW'(ClkDiv - 1);
    localparam logic [DurW-1:0] GapLast = (GapTicks > 0) ? DurW'(GapTicks - 1) : '0;
    localparam logic [IdxW-1:0] IdxMax  = IdxW'(NumLed - 1);

    typedef enum logic [1:0] {StIdle, StOn, StGap} state_e;

    state_e                  state_q;
    logic [PreW-1:0]         presc_q;
    logic [DurW-1:0]         cnt_q;
    logic [IdxW-1:0]         idx_q;
    logic [1:0]              mode_q;
    logic [NumLed*DurW-1:0]  dur_q;

    logic                    tick;
    logic [DurW-1:0]         sel_dur;
    logic [DurW-1:0]         on_last;
    logic                    phase_end;
    logic                    last_step;
    logic [IdxW-1:0]         step_idx;
    logic [IdxW-1:0]         start_idx;

    // Lit pattern for a given mode/index (all-blink lights everything).
    function automatic logic [NumLed-1:0] led_pattern(input logic [1:0]      md,
                                                      input logic [IdxW-1:0] idx);
        logic [NumLed-1:0] p;
        p = '1;
        for (int i = 0; i < NumLed; i++) begin
            if (md == ModeAll || idx == IdxW'(i)) begin
                p[i] = 1'b0;
            end
        end
        return p;
    endfunction

    function automatic logic [CurW-1:0] cur_value(input logic [1:0]      md,
                                                  input logic [IdxW-1:0] idx);
        return (md == ModeAll) ? '0 : CurW'(idx) + CurW'(1);
    endfunction

    always_comb begin
        tick = en_i && (state_q != StIdle) && (presc_q == PreLast);

        // On-time of the current phase; a zero field still lasts one tick.
        sel_dur = dur_q[DurW-1:0];
        if (mode_q != ModeAll) begin
            for (int i = 0; i < NumLed; i++) begin
                if (idx_q == IdxW'(i)) begin
                    sel_dur = dur_q[i*DurW +: DurW];
                end
            end
        end
        on_last = (sel_dur == '0) ? '0 : sel_dur - 1'b1;

        phase_end = (state_q == StOn) ? (cnt_q == on_last) : (cnt_q == GapLast);

        last_step = (mode_q == ModeAll)
                 || (mode_q == ModeFwd && idx_q == IdxMax)
                 || (mode_q == ModeRev && idx_q == '0);

        step_idx  = (mode_q == ModeRev) ? idx_q - 1'b1 : idx_q + 1'b1;
        start_idx = (mode_i == ModeRev) ? IdxMax : '0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            presc_q      <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
            mode_q       <= ModeFwd;
            dur_q        <= '0;
            led_n_o      <= '1;
            cur_idx_o    <= '0;
            frame_done_o <= 1'b0;
        end else begin
            // frame_done is an event, so it never stretches across a hold.
            frame_done_o <= 1'b0;
            if (en_i) begin
                unique case (state_q)
                    StIdle: begin
                        if (mode_i != ModeOff) begin
                            mode_q    <= mode_i;
                            dur_q     <= dur_i;
                            idx_q     <= start_idx;
                            cnt_q     <= '0;
                            presc_q   <= '0;
                            state_q   <= StOn;
                            led_n_o   <= led_pattern(mode_i, start_idx);
                            cur_idx_o <= cur_value(mode_i, start_idx);
                        end
                    end
                    StOn, StGap: begin
                        presc_q <= tick ? '0 : presc_q + 1'b1;
                        if (tick) begin
                            if (!phase_end) begin
                                cnt_q <= cnt_q + 1'b1;
                            end else begin
                                cnt_q <= '0;
                                if (state_q == StOn && GapTicks != 0) begin
                                    state_q   <= StGap;
                                    led_n_o   <= '1;
                                    cur_idx_o <= '0;
                                end else if (!last_step) begin
                                    idx_q     <= step_idx;
                                    state_q   <= StOn;
                                    led_n_o   <= led_pattern(mode_q, step_idx);
                                    cur_idx_o <= cur_value(mode_q, step_idx);
                                end else begin
                                    // Frame boundary: re-sample the controls.
                                    frame_done_o <= 1'b1;
                                    if (mode_i == ModeOff) begin
                                        state_q   <= StIdle;
                                        led_n_o   <= '1;
                                        cur_idx_o <= '0;
                                    end else begin
                                        mode_q    <= mode_i;
                                        dur_q     <= dur_i;
                                        idx_q     <= start_idx;
                                        state_q   <= StOn;
                                        led_n_o   <= led_pattern(mode_i, start_idx);
                                        cur_idx_o <= cur_value(mode_i, start_idx);
                                    end
                                end
                            end
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl. A frame-level model turns each sampled mode/dur into
// a list of output segments (pattern, cur_idx, length in clock cycles) and
// predicts every output change and frame_done pulse with its edge number. A
// separate monitor compares each observed change against the predicted queue.
module tb_led_seq_ctrl;

    localparam int unsigned ClkDiv   = 4;
    localparam int unsigned NumLed   = 4;
    localparam int unsigned DurW     = 4;
    localparam int unsigned GapTicks = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [1:0]  mode;
    logic [15:0] dur;
    logic [3:0]  led_n;
    logic [2:0]  cur_idx;
    logic        frame_done;

    always #5 clk = ~clk;

    led_seq_ctrl #(
        .ClkDiv   (ClkDiv),
        .NumLed   (NumLed),
        .DurW     (DurW),
        .GapTicks (GapTicks)
    ) u_dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .en_i         (en),
        .mode_i       (mode),
        .dur_i        (dur),
        .led_n_o      (led_n),
        .cur_idx_o    (cur_idx),
        .frame_done_o (frame_done)
    );

    typedef struct {
        logic [3:0]  led;
        logic [2:0]  cur;
        int unsigned cycles;
        bit          last;
    } seg_t;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  led;
        logic [2:0]  cur;
        logic        fd;
    } evt_t;

    evt_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    int unsigned edge_cnt = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Model state
    bit          m_active = 1'b0;
    seg_t        m_plan[$];
    seg_t        m_seg;
    int unsigned m_rem = 0;
    logic [3:0]  m_led = 4'b1111;
    logic [2:0]  m_cur = 3'd0;
    logic        m_fd  = 1'b0;
    logic [3:0]  p_led = 'x;
    logic [2:0]  p_cur = 'x;

    function automatic int unsigned on_cycles(input logic [15:0] d, input int i);
        int unsigned v;
        v = int'(d[i*4 +: 4]);
        return ((v == 0) ? 1 : v) * ClkDiv;
    endfunction

    task automatic build_plan(input logic [1:0] md, input logic [15:0] d);
        seg_t s;
        int   i;
        m_plan.delete();
        for (int k = 0; k < ((md == 2'd2) ? 1 : int'(NumLed)); k++) begin
            i = (md == 2'd1) ? int'(NumLed) - 1 - k : k;
            s.last = 1'b0;
            if (md == 2'd2) begin
                s.led = 4'b0000;
                s.cur = 3'd0;
            end else begin
                s.led    = 4'b1111;
                s.led[i] = 1'b0;
                s.cur    = 3'(i + 1);
            end
            s.cycles = on_cycles(d, i);
            m_plan.push_back(s);
            if (GapTicks > 0) begin
                s.led    = 4'b1111;
                s.cur    = 3'd0;
                s.cycles = GapTicks * ClkDiv;
                m_plan.push_back(s);
            end
        end
        s = m_plan.pop_back();
        s.last = 1'b1;
        m_plan.push_back(s);
    endtask

    task automatic next_seg();
        m_seg = m_plan.pop_front();
        m_rem = m_seg.cycles;
        m_led = m_seg.led;
        m_cur = m_seg.cur;
    endtask

    // Predict the outputs produced by the coming edge from the current inputs.
    task automatic model_edge();
        evt_t e;
        m_fd = 1'b0;
        if (!rst_n) begin
            m_active = 1'b0;
            m_plan.delete();
            m_led = 4'b1111;
            m_cur = 3'd0;
        end else if (en) begin
            if (!m_active) begin
                if (mode != 2'd3) begin
                    build_plan(mode, dur);
                    next_seg();
                    m_active = 1'b1;
                end
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    if (m_seg.last) begin
                        m_fd = 1'b1;
                        if (mode == 2'd3) begin
                            m_active = 1'b0;
                            m_led    = 4'b1111;
                            m_cur    = 3'd0;
                        end else begin
                            build_plan(mode, dur);
                            next_seg();
                        end
                    end else begin
                        next_seg();
                    end
                end
            end
        end
        if (m_led !== p_led || m_cur !== p_cur || m_fd) begin
            e.cyc = edge_cnt + 1;
            e.led = m_led;
            e.cur = m_cur;
            e.fd  = m_fd;
            exp_q.push_back(e);
        end
        p_led = m_led;
        p_cur = m_cur;
    endtask

    task automatic drive(input logic r, input logic e, input logic [1:0] md,
                         input logic [15:0] d);
        @(posedge clk);
        #1;
        rst_n = r;
        en    = e;
        mode  = md;
        dur   = d;
        model_edge();
    endtask

    // Monitor: every output change or frame_done pulse consumes one prediction.
    initial begin : monitor
        logic [3:0] ol;
        logic [2:0] oc;
        evt_t       e;
        ol = 'x;
        oc = 'x;
        forever begin
            @(negedge clk);
            if (led_n !== ol || cur_idx !== oc || frame_done !== 1'b0) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event: got cyc=%0d led_n=%b cur_idx=%0d fd=%b, want none",
                             edge_cnt, led_n, cur_idx, frame_done);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != edge_cnt || e.led !== led_n || e.cur !== cur_idx
                        || e.fd !== frame_done) begin
                        bad++;
                        $display("FAIL event: got cyc=%0d led_n=%b cur_idx=%0d fd=%b, want cyc=%0d led_n=%b cur_idx=%0d fd=%b",
                                 edge_cnt, led_n, cur_idx, frame_done,
                                 e.cyc, e.led, e.cur, e.fd);
                    end
                end
            end
            ol = led_n;
            oc = cur_idx;
        end
    end

    initial begin : stim
        logic [1:0]  md;
        logic [15:0] dd;
        rst_n = 1'b0;
        en    = 1'b1;
        mode  = 2'd0;
        dur   = 16'h4321;
        model_edge();
        repeat (2) drive(1'b0, 1'b1, 2'd0, 16'h4321);

        // Forward chase, led0..3 = 1,2,3,4 ticks, with a 10-cycle hold mid led1.
        for (int c = 0; c < 200; c++) drive(1'b1, !(c >= 14 && c < 24), 2'd0, 16'h4321);
        // Reverse chase, then all-blink with dur0 = 3.
        for (int c = 0; c < 150; c++) drive(1'b1, 1'b1, 2'd1, 16'h4321);
        for (int c = 0; c < 120; c++) drive(1'b1, 1'b1, 2'd2, 16'h4323);
        // Off request mid-frame, then a reset pulse, restart with dur0 = 0.
        for (int c = 0; c < 60; c++)  drive(1'b1, 1'b1, 2'd3, 16'h4320);
        for (int c = 0; c < 30; c++)  drive(1'b1, 1'b1, 2'd0, 16'h4320);
        drive(1'b0, 1'b1, 2'd0, 16'h4320);
        for (int c = 0; c < 80; c++)  drive(1'b1, 1'b1, 2'd0, 16'h4320);

        md = 2'd0;
        dd = 16'h1111;
        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(0, 119) == 0) begin
                md = ($urandom_range(0, 4) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                dd = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)),
                      4'($urandom_range(0, 5)), 4'($urandom_range(0, 5))};
            end
            drive($urandom_range(0, 299) != 0, $urandom_range(0, 15) != 0, md, dd);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_events: got %0d unobserved, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
